logic_unit_pipe: RTL
====================

# logic_unit_pipe

Parametrised, pipelined bitwise logic unit and the next generation of the two-input OR gate primitive. It generalises to WIDTH-bit operands and eight selectable operations, and adds Or-way style reduction flags. A valid/ready handshake runs at both ends, with a configurable register depth and bubble-collapsing backpressure. It sits between operand sources and the ALU/result bus wherever registered logic results are needed.

## Interface
- WIDTH, 16, operand/result width; legal range 1..64
- DEPTH, 2, pipeline register stages (= latency); legal range 1..8
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand beat offered
- in_ready  out  1  unit accepts beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  3  operation select
- out_valid  out  1  result beat offered
- out_ready  in  1  consumer accepts result
- out_y  out  WIDTH  result
- out_any  out  1  reduction OR of out_y
- out_zero  out  1  out_y == 0

## Operation
- in_op encoding:
  - 0 AND, 1 OR, 2 XOR, 3 NAND
  - 4 NOR, 5 XNOR, 6 NOT a (in_b ignored), 7 PASS a
- All codes are legal; no error path.
- Result y is evaluated combinationally from in_a/in_b/in_op at acceptance and captured into stage 0.
- any = |y and zero = ~|y are captured alongside y.
- Stages 1..DEPTH-1 carry {valid, y, any, zero} unchanged. Outputs are driven directly from stage DEPTH-1 registers.
- Advance chain:
  - adv[DEPTH-1] = !v[DEPTH-1] | out_ready
  - adv[i] = !v[i] | adv[i+1]
  - in_ready = adv[0] & rst_n
- Stage i loads on adv[i]:
  - v[i] <= upstream valid (in_valid for stage 0)
  - data loads only when upstream valid is 1; otherwise data holds.
- Bubbles collapse: an empty stage always accepts, so a stalled output fills all DEPTH stages before in_ready drops.
- Ordering is strict FIFO. No beat is dropped or duplicated.

## Timing
- Reset (rst_n=0 sampled at an edge):
  - all v <= 0; all y/any/zero <= 0.
  - After the reset edge: out_valid=0, out_y=0, out_any=0, out_zero=0.
  - in_ready=0 combinationally for the whole time rst_n=0.
- Reset mid-operation: all in-flight beats are discarded and never appear at the output. A beat offered in a reset cycle is not accepted.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready at the clock edge.
  - Output transfer occurs when out_valid & out_ready at the clock edge.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles of registering, when there is no stall.
- Throughput: one beat per cycle with out_ready held 1.
- Stall: while out_valid=1 and out_ready=0, out_y/out_any/out_zero hold stable.
- Full: all DEPTH stages valid and out_ready=0 gives in_ready=0 in the same cycle (combinational path out_ready -> in_ready).
- Simultaneous transfers: an output transfer and an input transfer in the same cycle when full are both legal. Occupancy is unchanged.
- in_valid may drop without a transfer. No input stability requirement is imposed on the source.

## Structure
- Package logic_pkg holds:
  - localparams OP_AND..OP_PASS (3-bit)
  - function logic_eval(a, b, op) returning the WIDTH-wide result; width is passed via parameterised function or max-width slice.
- One sub-module: logic_pipe_stage, holding a single {valid, y, any, zero} register with the adv/load logic. It is instantiated DEPTH times in a generate loop.
- Top module: op evaluation, reduction flags, ready chain.

## Test plan
(WIDTH=16, DEPTH=2 unless noted)
- Reset: rst_n=0 for 2 cycles -> out_valid=0, out_y=16'h0000, in_ready=0; release -> in_ready=1 next cycle.
- Truth table: a=16'h00FF, b=16'h0F0F, ops 0..7 back-to-back, out_ready=1 -> out_y sequence 000F, 0FFF, 0FF0, FFF0, F000, F00F, FF00, 00FF, one per cycle, first result 2 cycles after first accept.
- Flags:
  - OR a=0 b=0 -> out_any=0, out_zero=1.
  - OR a=16'h8000 b=0 -> out_any=1, out_zero=0.
  - WIDTH=1 AND 1,1 -> y=1, any=1.
- Backpressure: out_ready=0, offer 3 beats (OR of 1/2/3 with 0) -> first 2 accepted, in_ready=0 for the third, out_y holds 0001; raise out_ready -> outputs 0001, 0002, 0003 in order, no gaps after the third is accepted.
- Reset mid-flight: 2 beats in pipe, rst_n=0 one cycle -> out_valid=0 after the edge; those beats never appear; a fresh beat after release appears with normal latency.
- Bubble collapse, DEPTH=4: out_ready=0, one beat every other cycle -> in_ready stays 1 until 4 beats are held, then 0; output order preserved on release.

Source files
------------

// File: rtl/logic_pkg.sv
// Shared operation codes and the bitwise evaluation helper for the logic unit pipeline.
package logic_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  localparam int unsigned MAX_W = 64;

  // Evaluated at full width; callers keep the low WIDTH bits.
  function automatic logic [MAX_W-1:0] logic_eval(input logic [MAX_W-1:0] a,
                                                   input logic [MAX_W-1:0] b,
                                                   input op_e              op);
    logic [MAX_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_NOT:  r = ~a;
      OP_PASS: r = a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One pipeline register holding {valid, y, any, zero}; loads when the advance
// signal is high, and only captures data when the upstream beat is valid.
module logic_pipe_stage
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_y_i,
  input  logic             up_any_i,
  input  logic             up_zero_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] y_o,
  output logic             any_o,
  output logic             zero_o
);

  logic             valid_q;
  logic [WIDTH-1:0] y_q;
  logic             any_q;
  logic             zero_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      any_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (adv_i) begin
      valid_q <= up_valid_i;
      if (up_valid_i) begin
        y_q    <= up_y_i;
        any_q  <= up_any_i;
        zero_q <= up_zero_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign y_o     = y_q;
  assign any_o   = any_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit logic unit: evaluates one of eight bitwise ops at acceptance,
// then carries the result through DEPTH bubble-collapsing valid/ready stages.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_any,
  output logic             out_zero
);

  logic [MAX_W-1:0] a_ext, b_ext, y_full;
  logic [WIDTH-1:0] y_d;

  assign a_ext  = MAX_W'(in_a);
  assign b_ext  = MAX_W'(in_b);
  assign y_full = logic_eval(a_ext, b_ext, op_e'(in_op));
  assign y_d    = y_full[WIDTH-1:0];

  if (WIDTH < MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^y_full[MAX_W-1:WIDTH];
  end

  logic [DEPTH-1:0] v_q, any_q, zero_q;
  logic [WIDTH-1:0] y_q [DEPTH];
  logic [DEPTH-1:0] up_v, up_any, up_zero;
  logic [WIDTH-1:0] up_y [DEPTH];
  logic [DEPTH:0]   adv;

  // Walk from the output backwards so an empty stage always lets upstream advance.
  always_comb begin
    int unsigned idx;
    adv        = '0;
    adv[DEPTH] = out_ready;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx      = DEPTH - 1 - k;
      adv[idx] = !v_q[idx] | adv[idx+1];
    end
  end

  assign in_ready = adv[0] & rst_n;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign up_v[0]    = in_valid;
      assign up_y[0]    = y_d;
      assign up_any[0]  = |y_d;
      assign up_zero[0] = ~|y_d;
    end else begin : g_body
      assign up_v[g]    = v_q[g-1];
      assign up_y[g]    = y_q[g-1];
      assign up_any[g]  = any_q[g-1];
      assign up_zero[g] = zero_q[g-1];
    end

    logic_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .adv_i      (adv[g]),
      .up_valid_i (up_v[g]),
      .up_y_i     (up_y[g]),
      .up_any_i   (up_any[g]),
      .up_zero_i  (up_zero[g]),
      .valid_o    (v_q[g]),
      .y_o        (y_q[g]),
      .any_o      (any_q[g]),
      .zero_o     (zero_q[g])
    );
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_y     = y_q[DEPTH-1];
  assign out_any   = any_q[DEPTH-1];
  assign out_zero  = zero_q[DEPTH-1];

endmodule
